// File: rtl/dispatch_lane_splitter.sv
// dispatch_lane_splitter
//   Receives one instruction per issue slot, picks a slot round-robin and
//   streams the chosen instruction out as lane-wide packets.
//   There is one packet per live batch of NUM_LANES threads.
//   A batch is live when its slice of the thread mask is non-zero.
//   An all-zero mask still produces one packet, for batch 0.
//   While an instruction is being streamed, the splitter stays locked to its slot.
//   The slot's inputs are read live each cycle and are not captured.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   in_valid_i     per-slot instruction present
//   in_ready_o     per-slot consume pulse, same cycle the eop packet loads
//   in_tmask_i     per-slot thread mask      (ISSUE_CNT x THREAD_CNT)
//   in_hdr_i       per-slot header           (ISSUE_CNT x HDR_W)
//   in_data_i      per-slot thread operands  (ISSUE_CNT x THREAD_CNT x TDATA_W)
//   out_valid_o    registered packet valid
//   out_ready_i    downstream accept
//   out_isw_o      source issue slot
//   out_tmask_o    mask slice of this packet
//   out_hdr_o      header, unchanged
//   out_data_o     operands of threads pid*NUM_LANES+k
//   out_pid_o      batch index
//   out_sop_o      first packet of the instruction
//   out_eop_o      last packet of the instruction
module dispatch_lane_splitter #(
  parameter int ISSUE_CNT  = 4,
  parameter int THREAD_CNT = 4,
  parameter int NUM_LANES  = 2,
  parameter int HDR_W      = 64,
  parameter int TDATA_W    = 96,
  localparam int BATCHES   = THREAD_CNT / NUM_LANES,
  localparam int PID_W     = (BATCHES > 1) ? $clog2(BATCHES) : 1,
  localparam int ISW_W     = (ISSUE_CNT > 1) ? $clog2(ISSUE_CNT) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [ISSUE_CNT-1:0]                    in_valid_i,
  output logic [ISSUE_CNT-1:0]                    in_ready_o,
  input  logic [ISSUE_CNT*THREAD_CNT-1:0]         in_tmask_i,
  input  logic [ISSUE_CNT*HDR_W-1:0]              in_hdr_i,
  input  logic [ISSUE_CNT*THREAD_CNT*TDATA_W-1:0] in_data_i,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic [ISW_W-1:0]                        out_isw_o,
  output logic [NUM_LANES-1:0]                    out_tmask_o,
  output logic [HDR_W-1:0]                        out_hdr_o,
  output logic [NUM_LANES*TDATA_W-1:0]            out_data_o,
  output logic [PID_W-1:0]                        out_pid_o,
  output logic                                    out_sop_o,
  output logic                                    out_eop_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                       state_q;
  logic [ISW_W-1:0]             rr_q;
  logic [ISW_W-1:0]             lock_isw_q;
  logic [PID_W-1:0]             lock_pid_q;

  logic                         out_valid_q;
  logic [ISW_W-1:0]             out_isw_q;
  logic [NUM_LANES-1:0]         out_tmask_q;
  logic [HDR_W-1:0]             out_hdr_q;
  logic [NUM_LANES*TDATA_W-1:0] out_data_q;
  logic [PID_W-1:0]             out_pid_q;
  logic                         out_sop_q;
  logic                         out_eop_q;

  logic                         load_en;
  logic                         busy;
  logic                         fire;
  logic                         grant_found;
  logic [ISW_W-1:0]             grant_isw;
  logic [ISW_W-1:0]             cur_isw;
  logic [THREAD_CNT-1:0]        cur_mask;
  logic [BATCHES-1:0]           live;
  logic [PID_W-1:0]             first_pid;
  logic [PID_W-1:0]             cur_pid;
  logic                         has_next;
  logic [PID_W-1:0]             next_pid;
  logic [ISW_W-1:0]             rr_d;
  logic [NUM_LANES-1:0]         tmask_d;
  logic [HDR_W-1:0]             hdr_d;
  logic [NUM_LANES*TDATA_W-1:0] data_d;
  int                           idx;

  // Selection: arbitration, live-batch search and packet assembly
  always_comb begin
    load_en     = !out_valid_q || out_ready_i;
    busy        = (state_q == BUSY);

    grant_found = 1'b0;
    grant_isw   = '0;
    idx         = 0;
    for (int k = 0; k < ISSUE_CNT; k++) begin
      idx = (int'(rr_q) + k) % ISSUE_CNT;
      if (!grant_found && in_valid_i[ISW_W'(idx)]) begin
        grant_found = 1'b1;
        grant_isw   = ISW_W'(idx);
      end
    end

    cur_isw  = busy ? lock_isw_q : grant_isw;
    cur_mask = in_tmask_i[int'(cur_isw)*THREAD_CNT +: THREAD_CNT];

    live = '0;
    for (int b = 0; b < BATCHES; b++) begin
      live[b] = |cur_mask[b*NUM_LANES +: NUM_LANES];
    end
    // An empty mask still issues one packet so the instruction retires.
    if (cur_mask == '0) begin
      live[0] = 1'b1;
    end

    first_pid = '0;
    for (int b = BATCHES - 1; b >= 0; b--) begin
      if (live[b]) begin
        first_pid = PID_W'(b);
      end
    end
    cur_pid = busy ? lock_pid_q : first_pid;

    has_next = 1'b0;
    next_pid = '0;
    for (int b = BATCHES - 1; b >= 0; b--) begin
      if (live[b] && (b > int'(cur_pid))) begin
        has_next = 1'b1;
        next_pid = PID_W'(b);
      end
    end

    fire = load_en && (busy || grant_found);
    rr_d = (cur_isw == ISW_W'(ISSUE_CNT - 1)) ? '0 : cur_isw + 1'b1;

    tmask_d = cur_mask[int'(cur_pid)*NUM_LANES +: NUM_LANES];
    hdr_d   = in_hdr_i[int'(cur_isw)*HDR_W +: HDR_W];
    data_d  = in_data_i[(int'(cur_isw)*THREAD_CNT + int'(cur_pid)*NUM_LANES)*TDATA_W
                        +: NUM_LANES*TDATA_W];

    // The slot is released in the same cycle that its last packet loads.
    // Reset suppresses the release, so a half-streamed instruction is never acknowledged.
    in_ready_o = '0;
    if (fire && !has_next && !reset) begin
      in_ready_o[cur_isw] = 1'b1;
    end
  end

  // Output register, control half: lock/arbitration state and packet markers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      lock_isw_q  <= '0;
      lock_pid_q  <= '0;
      out_valid_q <= 1'b0;
      out_isw_q   <= '0;
      out_tmask_q <= '0;
      out_pid_q   <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else if (load_en) begin
      out_valid_q <= fire;
      if (fire) begin
        out_isw_q   <= cur_isw;
        out_tmask_q <= tmask_d;
        out_pid_q   <= cur_pid;
        out_sop_q   <= !busy;
        out_eop_q   <= !has_next;
        case (state_q)
          IDLE: begin
            if (has_next) begin
              state_q    <= BUSY;
              lock_isw_q <= cur_isw;
              lock_pid_q <= next_pid;
            end else begin
              rr_q <= rr_d;
            end
          end
          BUSY: begin
            if (has_next) begin
              lock_pid_q <= next_pid;
            end else begin
              state_q <= IDLE;
              rr_q    <= rr_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Output register, data half: header and operands (no reset)
  always_ff @(posedge clk) begin
    if (load_en && fire) begin
      out_hdr_q  <= hdr_d;
      out_data_q <= data_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_isw_o   = out_isw_q;
  assign out_tmask_o = out_tmask_q;
  assign out_hdr_o   = out_hdr_q;
  assign out_data_o  = out_data_q;
  assign out_pid_o   = out_pid_q;
  assign out_sop_o   = out_sop_q;
  assign out_eop_o   = out_eop_q;

endmodule

// File: tb/tb_dispatch_lane_splitter.sv
// tb_dispatch_lane_splitter
//   Scoreboard bench for dispatch_lane_splitter with the default geometry
//   (4 slots, 4 threads, 2 lanes).
//   Expected packets are queued in round-robin grant order when instructions
//   are presented. They are popped when the DUT loads a new packet.
//   Slot release pulses and the stability of held outputs are checked alongside.
module tb_dispatch_lane_splitter;
  localparam int N  = 4;
  localparam int T  = 4;
  localparam int NL = 2;
  localparam int HW = 64;
  localparam int W  = 96;
  localparam int B  = T / NL;
  localparam int PW = (B > 1) ? $clog2(B) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [IW-1:0]   isw;
    logic [PW-1:0]   pid;
    logic [NL-1:0]   tm;
    logic [HW-1:0]   hdr;
    logic [NL*W-1:0] data;
    logic            sop;
    logic            eop;
  } pkt_t;

  logic              clk;
  logic              reset;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready_o;
  logic [N*T-1:0]    in_tmask;
  logic [N*HW-1:0]   in_hdr;
  logic [N*T*W-1:0]  in_data;
  logic              out_valid_o;
  logic              out_ready;
  logic [IW-1:0]     out_isw_o;
  logic [NL-1:0]     out_tmask_o;
  logic [HW-1:0]     out_hdr_o;
  logic [NL*W-1:0]   out_data_o;
  logic [PW-1:0]     out_pid_o;
  logic              out_sop_o;
  logic              out_eop_o;

  dispatch_lane_splitter #(
    .ISSUE_CNT(N), .THREAD_CNT(T), .NUM_LANES(NL), .HDR_W(HW), .TDATA_W(W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .in_tmask_i(in_tmask), .in_hdr_i(in_hdr), .in_data_i(in_data),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .out_isw_o(out_isw_o), .out_tmask_o(out_tmask_o), .out_hdr_o(out_hdr_o),
    .out_data_o(out_data_o), .out_pid_o(out_pid_o),
    .out_sop_o(out_sop_o), .out_eop_o(out_eop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_pass = 0;
  pkt_t   q[$];
  pkt_t   last_pkt;
  logic   prev_load = 1'b0;
  logic [N-1:0] prev_rdy = '0;
  logic [N-1:0] pend = '0;
  int     rr_m = 0;
  logic   rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: every new packet is popped and compared.
  // Held packets must not change, and no slot may be released while held.
  always @(negedge clk) begin
    pkt_t e;
    logic [N-1:0] oh;
    if (!reset) begin
      if (prev_load) begin
        if (out_valid_o) begin
          if (q.size() == 0) begin
            chk("unexpected_pkt", {out_isw_o, out_pid_o}, '1);
          end else begin
            e = q.pop_front();
            chk("isw",   out_isw_o,   e.isw);
            chk("pid",   out_pid_o,   e.pid);
            chk("tmask", out_tmask_o, e.tm);
            chk("hdr",   out_hdr_o,   e.hdr);
            chk("data",  out_data_o,  e.data);
            chk("sop",   out_sop_o,   e.sop);
            chk("eop",   out_eop_o,   e.eop);
            oh = '0;
            if (e.eop) oh[e.isw] = 1'b1;
            chk("in_ready_at_load", prev_rdy, oh);
            last_pkt = e;
          end
        end else begin
          chk("in_ready_idle", prev_rdy, '0);
        end
      end else begin
        chk("in_ready_stall", prev_rdy, '0);
        chk("hold_valid", out_valid_o, 1'b1);
        chk("hold_pkt", {out_isw_o, out_pid_o, out_tmask_o, out_sop_o, out_eop_o, out_data_o},
            {last_pkt.isw, last_pkt.pid, last_pkt.tm, last_pkt.sop, last_pkt.eop, last_pkt.data});
      end
    end
    prev_load = !out_valid_o || out_ready;
    prev_rdy  = in_ready_o;
  end

  task automatic add_instr(input int s, input logic [T-1:0] m);
    in_tmask[s*T +: T]   = m;
    in_hdr[s*HW +: HW]   = {$urandom, $urandom};
    for (int t = 0; t < T; t++) in_data[(s*T+t)*W +: W] = {$urandom, $urandom, $urandom};
    in_valid[s] = 1'b1;
    pend[s]     = 1'b1;
  endtask

  // Queue the expected packets of all pending slots in round-robin order
  task automatic commit();
    int   s;
    int   last;
    int   lv[$];
    pkt_t p;
    last = rr_m;
    for (int k = 0; k < N; k++) begin
      s = (rr_m + k) % N;
      if (pend[s]) begin
        lv.delete();
        for (int b = 0; b < B; b++)
          if (in_tmask[s*T + b*NL +: NL] != '0) lv.push_back(b);
        if (lv.size() == 0) lv.push_back(0);
        for (int i = 0; i < lv.size(); i++) begin
          p.isw  = IW'(s);
          p.pid  = PW'(lv[i]);
          p.tm   = in_tmask[s*T + lv[i]*NL +: NL];
          p.hdr  = in_hdr[s*HW +: HW];
          p.data = in_data[(s*T + lv[i]*NL)*W +: NL*W];
          p.sop  = (i == 0);
          p.eop  = (i == lv.size() - 1);
          q.push_back(p);
        end
        pend[s] = 1'b0;
        last    = s;
      end
    end
    rr_m = (last + 1) % N;
  endtask

  // Run until every slot is released and every packet seen; bounded
  task automatic drain(input int budget);
    logic [N-1:0] rdy;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready_o;
      @(posedge clk);
      #1;
      in_valid  = in_valid & ~rdy;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (in_valid == '0 && q.size() == 0) break;
      cyc++;
      if (cyc > budget) begin
        chk("drain_timeout", {in_valid, 32'(q.size())}, '0);
        break;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; out_ready = 1'b1;
    in_tmask = '0; in_hdr = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_in_ready",  in_ready_o,  '0);
    chk("rst_sop_eop",   {out_sop_o, out_eop_o}, 2'b00);
    chk("rst_pid_isw",   {out_pid_o, out_isw_o}, '0);
    chk("rst_tmask",     out_tmask_o, '0);
    reset = 1'b0;

    // Full mask on slot 0: two packets
    add_instr(0, 4'b1111); commit(); drain(50);
    // Upper batch only on slot 2: single sop/eop packet with pid 1
    add_instr(2, 4'b1100); commit(); drain(50);
    // Empty mask on slot 3: one packet for batch 0
    add_instr(3, 4'b0000); commit(); drain(50);
    // All slots, full mask: no interleave, pointer wraps to 0
    for (int s = 0; s < N; s++) add_instr(s, 4'b1111);
    commit(); drain(100);
    chk("rr_wrap_model", rr_m, 0);

    // Downstream stall after the first packet
    add_instr(1, 4'b1111); commit();
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain(50);

    // Reset while locked: no release pulse, arbitration restarts at slot 0
    add_instr(2, 4'b1111); commit();
    @(posedge clk); #1;
    chk("rstbusy_first", {out_valid_o, out_isw_o, out_pid_o, out_sop_o, out_eop_o},
        {1'b1, 2'd2, 1'b0, 1'b1, 1'b0});
    reset = 1'b1;
    @(negedge clk);
    chk("rstbusy_in_ready", in_ready_o, '0);
    @(posedge clk); #1;
    chk("rstbusy_out_valid", out_valid_o, 1'b0);
    q.delete();
    rr_m = 0;
    pend[2] = 1'b1;
    add_instr(0, 4'b0110);
    commit();
    reset = 1'b0;
    drain(50);

    // Random traffic with random back-pressure
    rand_ready = 1'b1;
    for (int r = 0; r < 25; r++) begin
      for (int s = 0; s < N; s++)
        if ($urandom_range(0, 1) == 1) add_instr(s, 4'($urandom_range(0, 15)));
      if (pend == '0) add_instr(int'($urandom_range(0, N-1)), 4'($urandom_range(0, 15)));
      commit();
      drain(200);
    end
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dispatch_lane_splitter.md
# dispatch_lane_splitter

Receiving end of the per-issue-slot dispatch stream inside an execution unit. Takes one instruction per issue slot (full thread mask, header, per-thread operands), arbitrates round-robin across `ISSUE_CNT` slots, and serializes the chosen instruction into `THREAD_CNT/NUM_LANES` lane-wide packets. Packets whose thread-mask slice is empty are skipped. Output is one registered packet stream with start/end-of-instruction markers, feeding the unit's lane datapath.

## Interface
- ISSUE_CNT, 4, number of dispatch input slots (≥1)
- THREAD_CNT, 4, threads per instruction (power of 2)
- NUM_LANES, 2, lanes per output packet (power of 2, divides THREAD_CNT)
- HDR_W, 64, width of per-instruction header (uuid, wis, op, mod, rd, PC, ...)
- TDATA_W, 96, per-thread operand width (rs1/rs2/rs3)
- Derived: BATCHES = THREAD_CNT/NUM_LANES; PID_W = LOG2UP(BATCHES); ISW_W = LOG2UP(ISSUE_CNT)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  ISSUE_CNT  slot i holds an instruction
- in_ready  out  ISSUE_CNT  slot i instruction fully consumed
- in_tmask  in  ISSUE_CNT×THREAD_CNT  thread mask per slot
- in_hdr  in  ISSUE_CNT×HDR_W  header per slot
- in_data  in  ISSUE_CNT×THREAD_CNT×TDATA_W  operands per slot/thread
- out_valid  out  1  packet valid
- out_ready  in  1  downstream accepts packet
- out_isw  out  ISW_W  source issue slot
- out_tmask  out  NUM_LANES  mask slice of this packet
- out_hdr  out  HDR_W  header, copied unchanged
- out_data  out  NUM_LANES×TDATA_W  operands of threads pid×NUM_LANES+k
- out_pid  out  PID_W  batch index (0 when BATCHES=1)
- out_sop / out_eop  out  1  first / last packet of the instruction

## Operation
- Output register `load_en = !out_valid || out_ready`; all out_* change only when load_en; otherwise held stable.
- Batch b is "live" iff `in_tmask[slot][b*NUM_LANES +: NUM_LANES] != 0`. If the whole mask is zero, batch 0 counts as the sole live batch.
- States: IDLE (unlocked) and BUSY (locked to slot `lock_isw`, next batch `lock_pid`).
- IDLE: if any in_valid and load_en → grant = first valid slot at or after `rr_ptr` (wrapping); load first live batch, sop=1. If that batch is also the last live batch: eop=1, `in_ready[grant]=1` this cycle, `rr_ptr = grant+1` mod ISSUE_CNT, stay IDLE. Otherwise → BUSY with lock_pid = next live batch.
- BUSY: when load_en, load batch lock_pid from lock_isw, sop=0. If it is the last live batch: eop=1, in_ready[lock_isw]=1, rr_ptr = lock_isw+1, → IDLE. Else advance lock_pid to next live batch.
- No re-arbitration while BUSY; other slots wait. in_ready is never asserted for a non-granted slot, and at most one bit is set per cycle.
- Upstream holds valid/data stable until in_ready; the locked slot's data is read live (not captured).
- If load_en is low, out_valid stays 1 and out_* unchanged; in IDLE with out_valid=0 and no in_valid, out_valid goes 0 after out_ready.

## Timing
- Reset: out_valid=0, in_ready=0, out_sop=out_eop=0, out_pid=0, out_isw=0, out_tmask=0, state IDLE, rr_ptr=0. Header and data registers are don't-care.
- Latency: in_valid → out_valid next cycle.
- Throughput: 1 packet/cycle under continuous out_ready. An instruction with L live batches takes L cycles. A new instruction is issued back-to-back on the cycle after eop is loaded.
- in_ready is combinational, same cycle as its eop packet is loaded into the output register.
- Reset mid-BUSY: the lock is dropped, in_ready is not pulsed, and the partially issued instruction is discarded downstream by reset.

## Test plan
- T=4, L=2, slot0 tmask=1111, out_ready=1 → cycle1: pid0, sop1, eop0, tmask 11; cycle2: pid1, sop0, eop1; in_ready[0] high exactly on cycle 1 (load of pid1).
- slot2 tmask=1100 → single packet: isw2, pid1, sop=eop=1, out_data = threads 2,3; in_ready[2] pulses on the same cycle it loads.
- All 4 slots valid, tmask=1111 → packets ordered isw 0,0,1,1,2,2,3,3, with no interleave; rr_ptr wraps to 0.
- out_ready low for 5 cycles after the first packet → out_* stable, no in_ready; on release the pid1/eop packet follows with one pulse.
- tmask=0000 → one packet: pid0, sop=eop=1, tmask 00.
- reset asserted while BUSY → next cycle out_valid=0, in_ready=0; the next grant starts from slot 0.
